ahb_resp_mux: RTL
=================

Name: ahb_resp_mux

Overview:
- AHB-Lite return path for the uncore: the responder-side counterpart of the physical-address region decode.
- Registers the per-region select vector at the address phase. During the data phase it steers HRDATA/HREADYOUT/HRESP from the selected peripheral back to the initiator.
- Contains the default slave: any access that hits no region, or more than one region, gets a two-cycle AHB ERROR response.
- Keeps a saturating error counter and captures the address of the most recent faulting access for debug.

Parameters:
- XLEN, 64, bus data width in bits.
- PA_BITS, 56, physical address width.
- NREGIONS, 13, number of select lines; bit 0 means "no region selected".
- ERRCNT_BITS, 8, width of the error counter.

Ports:
- HCLK  input  1  bus clock.
- HRESETn  input  1  reset, asynchronous, active-low.
- HSELRegions  input  NREGIONS  address-phase region selects; bit 0 = unmapped.
- HADDR  input  PA_BITS  address-phase address.
- HTRANS  input  2  address-phase transfer type.
- HREADY  input  1  global bus ready; this is the module's own HREADYOUT fed back.
- HRDATAPer  input  NREGIONS*XLEN  per-region read data; slice i = bits [i*XLEN +: XLEN]; slice 0 unused.
- HREADYOUTPer  input  NREGIONS  per-region ready; bit 0 ignored.
- HRESPPer  input  NREGIONS  per-region response; bit 0 ignored.
- HRDATA  output  XLEN  read data to initiator.
- HREADYOUT  output  1  ready to initiator.
- HRESP  output  1  response to initiator; 1 = ERROR.
- ErrCount  output  ERRCNT_BITS  number of default-slave errors, saturating.
- ErrAddr  output  PA_BITS  HADDR of the most recent errored transfer.

Behaviour:
- Reset (HRESETn=0, async): SelD=0, state IDLE, ErrCount=0, ErrAddr=0.
  - Outputs during reset: HREADYOUT=1, HRESP=0, HRDATA=0.
  - Reset asserted mid-ERR1/ERR2 aborts the error response immediately.
- Address-phase accept: HREADY=1 and HTRANS[1]=1 (NONSEQ or SEQ).
- On every HREADY=1 edge, SelD is loaded as follows:
  - Accepted transfer with exactly one bit of HSELRegions[NREGIONS-1:1] set and bit 0 clear: SelD = HSELRegions.
  - Accepted transfer otherwise (bit 0 set, zero bits set, or more than one set): SelD = 0 and the FSM goes to ERR1.
  - No accepted transfer (IDLE/BUSY): SelD = 0. IDLE/BUSY to an unmapped address never errors.
- HREADY=0: SelD and FSM hold. Extended data phases are supported.
- Data-phase mux:
  - SelD one-hot: drive the selected slice of HRDATAPer, HREADYOUTPer and HRESPPer, purely combinationally (zero added latency).
  - SelD=0 and state IDLE: HREADYOUT=1, HRESP=0, HRDATA=0.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 on an erroring accept.
  - ERR1: HREADYOUT=0, HRESP=1, HRDATA=0. Always -> ERR2 next cycle.
  - ERR2: HREADYOUT=1, HRESP=1, HRDATA=0.
  - Leaving ERR2: a new accept this cycle (HREADY=1) is evaluated normally. Another erroring accept -> ERR1; otherwise -> IDLE with the new SelD.
  - Back-to-back errors therefore give the pattern ERR1, ERR2, ERR1, ERR2.
- Error bookkeeping:
  - On each IDLE/ERR2 -> ERR1 transition: ErrAddr <= HADDR of the faulting address phase.
  - On the same transition, ErrCount increments, saturating at 2^ERRCNT_BITS-1 with no wrap.
  - ErrAddr and ErrCount are cleared only by reset.
- Per-region HRESP from a real slave passes through unchanged. It is not counted in ErrCount and not captured in ErrAddr.
- HADDR is only sampled on erroring accepts.

Test Plan:
- Reset then idle: after HRESETn deasserts, HTRANS=0 for 5 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0, ErrCount=0.
- Mapped read: region 5 selected, HTRANS=2'b10. Next cycle HREADYOUTPer[5]=0 for 2 cycles, then 1 with HRDATAPer slice 5 = 64'hDEADBEEF_CAFEF00D -> HREADYOUT low for 2 cycles, then HRDATA=64'hDEADBEEF_CAFEF00D with HRESP=0.
- Unmapped access: HSELRegions=13'h0001, HADDR=56'h0000_0090_0000, NONSEQ -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1). ErrCount=1, ErrAddr=56'h90_0000.
- Multi-hit select: HSELRegions=13'h0060 (regions 5 and 6) -> same two-cycle ERROR response; ErrCount increments.
- Back-to-back errors: unmapped NONSEQ issued in ERR2, repeated 300 times -> repeating ERR1/ERR2 pattern; ErrCount saturates at 255; ErrAddr = last address.
- Async reset mid-error: assert HRESETn=0 during ERR1 -> HREADYOUT=1, HRESP=0, ErrCount=0 without waiting for a clock edge; IDLE after release.

Source files
------------

// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - AHB-Lite response mux with default slave and error capture
module ahb_resp_mux #(
    parameter int XLEN        = 64,
    parameter int PA_BITS     = 56,
    parameter int NREGIONS    = 13,
    parameter int ERRCNT_BITS = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NREGIONS-1:0]      HSELRegions,
    input  logic [PA_BITS-1:0]       HADDR,
    input  logic [1:0]               HTRANS,
    input  logic                     HREADY,
    input  logic [NREGIONS*XLEN-1:0] HRDATAPer,
    input  logic [NREGIONS-1:0]      HREADYOUTPer,
    input  logic [NREGIONS-1:0]      HRESPPer,
    output logic [XLEN-1:0]          HRDATA,
    output logic                     HREADYOUT,
    output logic                     HRESP,
    output logic [ERRCNT_BITS-1:0]   ErrCount,
    output logic [PA_BITS-1:0]       ErrAddr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NREGIONS-1:0]  sel_d;
    logic [NREGIONS-2:0]  sel_hi;
    logic                 sel_onehot;
    logic                 accept;
    logic                 err_accept;
    logic                 err_enter;
    logic                 unused_htrans0;

    // Only HTRANS[1] distinguishes active (NONSEQ/SEQ) from IDLE/BUSY.
    assign unused_htrans0 = HTRANS[0];

    // A good select has exactly one mapped region and the unmapped bit clear.
    assign sel_hi     = HSELRegions[NREGIONS-1:1];
    assign sel_onehot = ~HSELRegions[0] && (sel_hi != '0) &&
                        ((sel_hi & (sel_hi - 1'b1)) == '0);
    assign accept     = HREADY & HTRANS[1];
    assign err_accept = accept & ~sel_onehot;
    // ERR1 always proceeds to ERR2, so a new error can only start from IDLE or ERR2.
    assign err_enter  = err_accept && (state != ST_ERR1);

    // Data-phase select register, advanced only when the bus moves forward.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_d <= '0;
        end else if (HREADY) begin
            sel_d <= (accept && sel_onehot) ? HSELRegions : '0;
        end
    end

    // Default-slave state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Default-slave next state: two-cycle error, new accepts evaluated in ERR2.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ERR2: begin
                if (HREADY) begin
                    state_nxt = err_accept ? ST_ERR1 : ST_IDLE;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response steering: default slave overrides, else the selected region passes through.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        case (state)
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                HRESP     = 1'b1;
            end
            default: begin
                for (int i = 0; i < NREGIONS; i++) begin
                    if (sel_d[i]) begin
                        HRDATA    = HRDATAPer[i*XLEN +: XLEN];
                        HREADYOUT = HREADYOUTPer[i];
                        HRESP     = HRESPPer[i];
                    end
                end
            end
        endcase
    end

    // Debug capture: faulting address and saturating count of default-slave errors.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ErrCount <= '0;
            ErrAddr  <= '0;
        end else if (err_enter) begin
            ErrAddr <= HADDR;
            if (ErrCount != '1) begin
                ErrCount <= ErrCount + 1'b1;
            end
        end
    end

endmodule
